// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern engine: mode encodings and bounce FSM states.
package led_pattern_pkg;

    localparam logic [1:0] MODE_ROL    = 2'b00;
    localparam logic [1:0] MODE_ROR    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } bounce_state_t;

endpackage

// File: rtl/tick_divider.sv
// Clock-enable divider: pulses tick for one cycle every DIV cycles of run=1; holds while run=0.
module tick_divider
    import led_pattern_pkg::*;
#(
    parameter int DIV = 25000000
) (
    input  logic initial_clk,
    input  logic initial_reset,
    input  logic run,
    output logic tick
);

    localparam int             CW   = $clog2(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = run && (count == LAST);

    always_ff @(posedge initial_clk) begin
        if (initial_reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (run) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: rotate-left/right, bounce and hold on a divided clock-enable.
// Bounce FSM is present only when LED_BOUNCE_EN is defined; otherwise mode 10 acts as hold.
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DIV   = 25000000,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             initial_clk,
    input  logic             initial_reset,
    input  logic             run,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] rotate_answer,
    output logic             step_tick,
    output logic             wrap
);

    logic             tick;
    logic             div_clear;
    logic [WIDTH-1:0] pat_next;
    logic             wrap_next;
    logic [WIDTH-1:0] rol;
    logic [WIDTH-1:0] ror;

    // A load restarts the step period, so it clears the divider like a reset.
    assign div_clear = initial_reset | load;

    tick_divider #(
        .DIV(DIV)
    ) u_div (
        .initial_clk  (initial_clk),
        .initial_reset(div_clear),
        .run          (run),
        .tick         (tick)
    );

    assign rol = {rotate_answer[WIDTH-2:0], rotate_answer[WIDTH-1]};
    assign ror = {rotate_answer[0], rotate_answer[WIDTH-1:1]};

`ifdef LED_BOUNCE_EN
    bounce_state_t state;
    bounce_state_t state_next;

    always_ff @(posedge initial_clk) begin
        if (initial_reset) begin
            state <= UP;
        end else if (load) begin
            state <= UP;
        end else if (tick) begin
            state <= state_next;
        end
    end
`endif

    always_comb begin
        pat_next  = rotate_answer;
        wrap_next = 1'b0;
`ifdef LED_BOUNCE_EN
        state_next = state;
`endif
        case (mode)
            MODE_ROL: begin
                pat_next  = rol;
                wrap_next = rotate_answer[WIDTH-1];
            end
            MODE_ROR: begin
                pat_next  = ror;
                wrap_next = rotate_answer[0];
            end
`ifdef LED_BOUNCE_EN
            MODE_BOUNCE: begin
                // Reversal and the first step in the new direction happen together.
                if (state == UP) begin
                    if (rotate_answer[WIDTH-1]) begin
                        state_next = DOWN;
                        pat_next   = ror;
                        wrap_next  = 1'b1;
                    end else begin
                        pat_next = rol;
                    end
                end else begin
                    if (rotate_answer[0]) begin
                        state_next = UP;
                        pat_next   = rol;
                        wrap_next  = 1'b1;
                    end else begin
                        pat_next = ror;
                    end
                end
            end
`endif
            default: begin
                pat_next  = rotate_answer;
                wrap_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge initial_clk) begin
        if (initial_reset) begin
            rotate_answer <= SEED;
            step_tick     <= 1'b0;
            wrap          <= 1'b0;
        end else if (load) begin
            rotate_answer <= load_data;
            step_tick     <= 1'b0;
            wrap          <= 1'b0;
        end else begin
            step_tick <= tick;
            wrap      <= tick & wrap_next;
            if (tick) begin
                rotate_answer <= pat_next;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine (DIV=4, WIDTH=8, SEED=01); covers bounce when LED_BOUNCE_EN is set.
module tb_led_pattern_engine;

    logic       clk;
    logic       rst;
    logic       run;
    logic [1:0] mode;
    logic       load;
    logic [7:0] load_data;
    logic [7:0] rotate_answer;
    logic       step_tick;
    logic       wrap;

    int unsigned vectors;
    int unsigned miscompares;

    led_pattern_engine #(
        .WIDTH(8),
        .DIV  (4),
        .SEED (8'h01)
    ) dut (
        .initial_clk  (clk),
        .initial_reset(rst),
        .run          (run),
        .mode         (mode),
        .load         (load),
        .load_data    (load_data),
        .rotate_answer(rotate_answer),
        .step_tick    (step_tick),
        .wrap         (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the next step_tick, then check spacing, pattern and wrap.
    task automatic wait_step(input string tag, input logic [7:0] exp_pat,
                             input logic exp_wrap, input int unsigned exp_gap);
        int unsigned n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!step_tick && n < 16);
        check_val({tag, "_gap"}, n, exp_gap);
        check_val({tag, "_pat"}, {24'h0, rotate_answer}, {24'h0, exp_pat});
        check_val({tag, "_wrap"}, {31'h0, wrap}, {31'h0, exp_wrap});
    endtask

    task automatic do_load(input logic [7:0] d);
        load      = 1'b1;
        load_data = d;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        logic [7:0] p;
        logic       frozen;
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        run       = 1'b0;
        mode      = 2'b00;
        load      = 1'b0;
        load_data = 8'h00;
        cyc();
        cyc();
        check_val("rst_pat", {24'h0, rotate_answer}, 32'h01);
        check_val("rst_step", {31'h0, step_tick}, 32'h0);
        check_val("rst_wrap", {31'h0, wrap}, 32'h0);

        // Rotate left through a full cycle
        rst = 1'b0;
        run = 1'b1;
        p   = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = p << 1;
            wait_step("rol", p, 1'b0, 4);
        end
        wait_step("rol_wrap", 8'h01, 1'b1, 4);
        cyc();
        check_val("step_one_cycle", {31'h0, step_tick}, 32'h0);
        check_val("wrap_one_cycle", {31'h0, wrap}, 32'h0);

        // Load 81 then rotate right
        mode = 2'b01;
        do_load(8'h81);
        check_val("load_pat", {24'h0, rotate_answer}, 32'h81);
        wait_step("ror1", 8'hC0, 1'b1, 4);
        wait_step("ror2", 8'h60, 1'b0, 4);

`ifdef LED_BOUNCE_EN
        mode = 2'b10;
        do_load(8'h01);
        p = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = p << 1;
            wait_step("bnc_up", p, 1'b0, 4);
        end
        wait_step("bnc_rev_dn", 8'h40, 1'b1, 4);
        p = 8'h40;
        for (int i = 0; i < 6; i++) begin
            p = p >> 1;
            wait_step("bnc_dn", p, 1'b0, 4);
        end
        wait_step("bnc_rev_up", 8'h02, 1'b1, 4);
        do_load(8'h00);
        for (int i = 0; i < 3; i++) begin
            wait_step("bnc_zero", 8'h00, 1'b0, 4);
        end
`else
        mode = 2'b10;
        do_load(8'h01);
        for (int i = 0; i < 3; i++) begin
            wait_step("m10_hold", 8'h01, 1'b0, 4);
        end
`endif

        // Hold mode keeps ticking without changing the pattern
        mode = 2'b11;
        do_load(8'h5A);
        wait_step("hold1", 8'h5A, 1'b0, 4);
        wait_step("hold2", 8'h5A, 1'b0, 4);

        // Freeze mid-count, then resume from the held count
        mode = 2'b00;
        do_load(8'h01);
        cyc();
        cyc();
        run    = 1'b0;
        frozen = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (rotate_answer !== 8'h01 || step_tick !== 1'b0) frozen = 1'b0;
        end
        check_val("freeze", {31'h0, frozen}, 32'h1);
        run = 1'b1;
        wait_step("resume", 8'h02, 1'b0, 2);

        // Load coincident with a tick wins, and restarts the period
        cyc();
        cyc();
        cyc();
        do_load(8'hF0);
        check_val("ld_tick_pat", {24'h0, rotate_answer}, 32'hF0);
        check_val("ld_tick_step", {31'h0, step_tick}, 32'h0);
        check_val("ld_tick_wrap", {31'h0, wrap}, 32'h0);
        wait_step("after_ld", 8'hE1, 1'b1, 4);

        // Reset mid-count
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        check_val("mid_rst_pat", {24'h0, rotate_answer}, 32'h01);
        check_val("mid_rst_step", {31'h0, step_tick}, 32'h0);
        rst = 1'b0;
        wait_step("post_rst", 8'h02, 1'b0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_pattern_engine.md
LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, giving the pattern width in bits (legal range 2..32).
REQ-002 The block SHALL provide parameter DIV, default 25000000, giving the number of initial_clk cycles per pattern step (DIV >= 2).
REQ-003 The block SHALL provide parameter SEED, default 1 (WIDTH bits), giving the reset pattern.
REQ-004 The block SHALL have port initial_clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port initial_reset, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port run, input, 1 bit; 1 = stepping enabled, 0 = freeze.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 rotate-left, 01 rotate-right, 10 bounce, 11 hold.
REQ-008 The block SHALL have port load, input, 1 bit, a one-cycle request to load a new pattern.
REQ-009 The block SHALL have port load_data, input, WIDTH bits, the pattern captured on load.
REQ-010 The block SHALL have port rotate_answer, output, WIDTH bits, the registered pattern.
REQ-011 The block SHALL have port step_tick, output, 1 bit, a one-cycle pulse marking each pattern update.
REQ-012 The block SHALL have port wrap, output, 1 bit, a one-cycle pulse on wrap or direction reversal.

Function
REQ-013 Clock derivation SHALL be a clock-enable only; no derived or gated clock shall be created.
REQ-014 The divider counter SHALL count 0..DIV-1 only while run=1, SHALL hold its value while run=0, and SHALL raise an internal tick in the cycle it equals DIV-1 with run=1, then return to 0.
REQ-015 On a tick, rotate_answer SHALL update at the next rising edge, and step_tick SHALL be 1 for exactly that one cycle in which the new value first appears.
REQ-016 On a tick in rotate-left mode, rotate_answer SHALL become {rotate_answer[WIDTH-2:0], rotate_answer[WIDTH-1]}.
REQ-017 On a tick in rotate-right mode, rotate_answer SHALL become {rotate_answer[0], rotate_answer[WIDTH-1:1]}.
REQ-018 Bounce mode SHALL use an FSM with states UP and DOWN.
REQ-019 In bounce state UP, a tick SHALL rotate left when rotate_answer[WIDTH-1]=0; otherwise it SHALL move to DOWN and rotate right in the same step.
REQ-020 In bounce state DOWN, a tick SHALL rotate right when rotate_answer[0]=0; otherwise it SHALL move to UP and rotate left in the same step.
REQ-021 In hold mode, the divider SHALL keep counting and step_tick SHALL still pulse, but rotate_answer and the FSM state SHALL be unchanged.
REQ-022 The wrap output SHALL pulse, aligned with step_tick, in these cases:
  - rotate-left tick where the pre-step MSB=1;
  - rotate-right tick where the pre-step LSB=1;
  - any bounce direction reversal.
REQ-023 Load SHALL take priority over a simultaneous tick: rotate_answer becomes load_data, the divider clears to 0, the FSM goes to UP, and step_tick and wrap stay 0 that cycle.
REQ-024 A mode change SHALL take effect on the next tick; the FSM state SHALL be retained across mode changes.
REQ-025 An all-zero pattern in bounce mode SHALL never reverse direction and SHALL stay at zero with no wrap.

Reset
REQ-026 On initial_reset=1 at a rising edge, the block SHALL set:
  - rotate_answer = SEED;
  - divider = 0;
  - FSM = UP;
  - step_tick = 0;
  - wrap = 0.
REQ-027 Reset SHALL override load, tick and run, including when asserted mid-count.

Configuration
REQ-028 With macro LED_BOUNCE_EN defined, the block SHALL include the bounce FSM and mode 10 SHALL behave per REQ-018..REQ-020.
REQ-029 Without LED_BOUNCE_EN, the bounce FSM SHALL be absent and mode 10 SHALL behave exactly as hold (mode 11).

Structure
REQ-030 A shared package led_pattern_pkg SHALL hold the mode encoding constants (MODE_ROL, MODE_ROR, MODE_BOUNCE, MODE_HOLD) and the FSM state typedef (UP, DOWN).
REQ-031 The divider SHALL be a separate sub-module tick_divider, parametrised by DIV, with ports initial_clk, initial_reset, run and tick.

Verification (DIV=4, WIDTH=8, SEED=8'h01, LED_BOUNCE_EN defined unless stated)
REQ-032 Reset, then mode=00, run=1: rotate_answer SHALL read 01, 02, 04 ... 80, 01; step_tick SHALL pulse every 4 cycles; wrap SHALL pulse with the 80->01 step.
REQ-033 Load 8'h81, then mode=01: rotate_answer SHALL read C0, 60; wrap SHALL pulse on the first step only (pre-step LSB=1).
REQ-034 Mode=10 from 01: rotate_answer SHALL read 02 ... 80, then 40; wrap SHALL pulse on the 80->40 step; the sequence SHALL continue down to 01, then back to 02 with wrap.
REQ-035 run=0 for 10 cycles mid-count: rotate_answer and step_tick SHALL be frozen; after run returns to 1, the tick SHALL resume from the held count.
REQ-036 load asserted in the same cycle as a tick: rotate_answer = load_data, no step_tick, and the next step_tick SHALL come 4 cycles later.
REQ-037 Without LED_BOUNCE_EN, mode=10: rotate_answer SHALL stay constant while step_tick keeps pulsing; initial_reset mid-count SHALL restore 01 on the next edge.
